// File: rtl/s7_inverse_search_if.sv
// Request/result bus for the S7 inverse search block.
// The master side issues searches and consumes preimages; the slave side is the searcher.
interface s7_inverse_search_if;
   logic       req_valid;
   logic [3:0] req_value;
   logic       req_ready;
   logic       abort;
   logic       res_valid;
   logic [5:0] res_data;
   logic       res_last;
   logic       res_ready;
   logic       done;
   logic [2:0] match_count;

   modport master (
      output req_valid, req_value, abort, res_ready,
      input  req_ready, res_valid, res_data, res_last, done, match_count
   );

   modport slave (
      input  req_valid, req_value, abort, res_ready,
      output req_ready, res_valid, res_data, res_last, done, match_count
   );
endinterface

// File: rtl/s7_inverse_search.sv
// Exhaustive inverse of the DES S7 box: walks all 64 inputs in ascending order and
// streams every input whose S7 output equals the requested 4-bit target.

module s7_lookup (
   input  logic [5:0] din,
   output logic [3:0] dout
);
   // Each row packs its 16 columns as nibbles, column 0 in the least significant nibble.
   localparam logic [63:0] row0_tab = 64'h16A579C3D80FE2B4;
   localparam logic [63:0] row1_tab = 64'h68F2C53EA1947B0D;
   localparam logic [63:0] row2_tab = 64'h295086FAE73CDB41;
   localparam logic [63:0] row3_tab = 64'hC32EF0597A418DB6;

   logic [1:0]  row;
   logic [3:0]  col;
   logic [63:0] row_bits;

   assign row = {din[5], din[0]};
   assign col = din[4:1];

   always_comb begin
      case (row)
         2'd0:    row_bits = row0_tab;
         2'd1:    row_bits = row1_tab;
         2'd2:    row_bits = row2_tab;
         default: row_bits = row3_tab;
      endcase
   end

   assign dout = row_bits[{col, 2'b00} +: 4];
endmodule

module s7_inverse_search (
   input  logic                  clk,
   input  logic                  reset,
   s7_inverse_search_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

   state_t     state, state_n;
   logic [5:0] cnt, cnt_n;
   logic [3:0] target, target_n;
   logic [5:0] res_data, res_data_n;
   logic       res_valid, res_valid_n;
   logic       res_last, res_last_n;
   logic       done, done_n;
   logic [2:0] match_count, match_count_n;
   logic       req_ready, req_ready_n;
   logic [3:0] s7_out;

   s7_lookup u_s7 (
      .din  (cnt),
      .dout (s7_out)
   );

   // NOTE: every next-state variable gets its hold value first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      target_n      = target;
      res_data_n    = res_data;
      res_valid_n   = res_valid;
      res_last_n    = res_last;
      done_n        = 1'b0;
      match_count_n = match_count;

      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               target_n      = bus.req_value;
               cnt_n         = 6'd0;
               match_count_n = 3'd0;
               state_n       = SCAN;
            end
         end
         SCAN: begin
            if (bus.abort) begin
               res_valid_n = 1'b0;
               res_last_n  = 1'b0;
               state_n     = IDLE;
            end else if (s7_out == target) begin
               res_data_n  = cnt;
               res_valid_n = 1'b1;
               res_last_n  = (match_count == 3'd3);
               state_n     = HOLD;
            end else if (cnt == 6'd63) begin
               done_n  = 1'b1;
               state_n = DONE;
            end else begin
               cnt_n = cnt + 6'd1;
            end
         end
         HOLD: begin
            // Abort wins over a simultaneous consumer handshake.
            if (bus.abort) begin
               res_valid_n = 1'b0;
               res_last_n  = 1'b0;
               state_n     = IDLE;
            end else if (bus.res_ready) begin
               res_valid_n   = 1'b0;
               res_last_n    = 1'b0;
               match_count_n = (match_count == 3'd4) ? 3'd4 : match_count + 3'd1;
               if (cnt == 6'd63) begin
                  done_n  = 1'b1;
                  state_n = DONE;
               end else begin
                  cnt_n   = cnt + 6'd1;
                  state_n = SCAN;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      req_ready_n = (state_n == IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 6'd0;
         target      <= 4'd0;
         res_data    <= 6'd0;
         res_valid   <= 1'b0;
         res_last    <= 1'b0;
         done        <= 1'b0;
         match_count <= 3'd0;
         req_ready   <= 1'b1;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         target      <= target_n;
         res_data    <= res_data_n;
         res_valid   <= res_valid_n;
         res_last    <= res_last_n;
         done        <= done_n;
         match_count <= match_count_n;
         req_ready   <= req_ready_n;
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.res_valid   = res_valid;
   assign bus.res_data    = res_data;
   assign bus.res_last    = res_last;
   assign bus.done        = done;
   assign bus.match_count = match_count;
endmodule

// File: tb/tb_s7_inverse_search.sv
// Scoreboard bench for s7_inverse_search: a table-driven S7 model predicts every
// preimage stream, and an independent monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_s7_inverse_search;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   s7_inverse_search_if bus ();

   s7_inverse_search dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic fail_now(input string name, input string detail);
      tests++;
      fails++;
      $display("FAIL %s: %s (t=%0t)", name, detail, $time);
   endtask

   // DES S7 in its textbook form: row = {b6,b1}, column = b5..b2.
   int s7_tab [4][16] = '{
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1},
      '{13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6},
      '{ 1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2},
      '{ 6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12}
   };

   function automatic int s7_ref(input int x);
      int row, col;
      row = ((x >> 5) & 1) * 2 + (x & 1);
      col = (x >> 1) & 15;
      return s7_tab[row][col];
   endfunction

   typedef struct {
      int   data;
      logic last;
   } exp_t;

   exp_t exp_q[$];
   int   cur_target = 0;
   int   last_res   = -1;
   int   done_count = 0;
   time  last_hs_time = 0;
   int   rr_mode = 0;   // 0: always ready, 1: random, 2: five stall cycles per result

   task automatic push_expected(input int t);
      int   n;
      exp_t e;
      n = 0;
      for (int x = 0; x < 64; x++) begin
         if (s7_ref(x) == t) begin
            e.data = x;
            e.last = (n == 3);
            exp_q.push_back(e);
            n++;
         end
      end
   endtask

   // Consumer: drives res_ready just after each rising edge.
   initial begin
      int stall;
      stall = 0;
      bus.res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0: bus.res_ready = 1'b1;
            1: bus.res_ready = 1'($urandom_range(0, 1));
            default: begin
               if (!bus.res_valid) begin
                  stall = 0;
                  bus.res_ready = 1'b0;
               end else if (stall < 5) begin
                  stall++;
                  bus.res_ready = 1'b0;
               end else begin
                  stall = 0;
                  bus.res_ready = 1'b1;
               end
            end
         endcase
      end
   end

   // Monitor: samples on the falling edge, between input updates and the next capture edge.
   initial begin
      logic       prev_hold;
      logic [5:0] prev_data;
      logic       prev_last;
      logic       prev_done;
      exp_t       e;
      prev_hold = 1'b0;
      prev_data = 6'd0;
      prev_last = 1'b0;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_hold = 1'b0;
            prev_done = 1'b0;
         end else begin
            if (prev_hold) begin
               check("hold_valid", 32'(bus.res_valid), 32'd1);
               check("hold_data",  32'(bus.res_data), 32'(prev_data));
               check("hold_last",  32'(bus.res_last), 32'(prev_last));
            end
            if (bus.res_valid && bus.res_ready && !bus.abort) begin
               if (exp_q.size() == 0) begin
                  fail_now("spurious_result", $sformatf("got res_data=%0d, expected no result", bus.res_data));
               end else begin
                  e = exp_q.pop_front();
                  check("res_data", 32'(bus.res_data), 32'(e.data));
                  check("res_last", 32'(bus.res_last), 32'(e.last));
               end
               check("s7_of_result", 32'(s7_ref(int'(bus.res_data))), 32'(cur_target));
               check("ascending", 32'(int'(bus.res_data) > last_res), 32'd1);
               last_res     = int'(bus.res_data);
               last_hs_time = $time;
            end
            if (bus.done) begin
               done_count++;
               check("done_match_count", 32'(bus.match_count), 32'd4);
               check("done_single_cycle", 32'(prev_done), 32'd0);
            end
            prev_hold = bus.res_valid && !bus.res_ready && !bus.abort;
            prev_data = bus.res_data;
            prev_last = bus.res_last;
            prev_done = bus.done;
         end
      end
   end

   // Caller is just after a rising edge with the DUT idle; returns just after the acceptance edge.
   task automatic issue(input int t, input logic with_abort);
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      cur_target    = t;
      last_res      = -1;
      push_expected(t);
      bus.req_value = 4'(t);
      bus.req_valid = 1'b1;
      bus.abort     = with_abort;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.abort     = 1'b0;
   endtask

   // Counts cycles after acceptance (first SCAN cycle is 1) until done is seen.
   task automatic wait_done(input int budget, output int cyc);
      cyc = 1;
      while (!bus.done && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!bus.done) fail_now("done_timeout", $sformatf("no done within %0d cycles", budget));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req_ready"},   32'(bus.req_ready),   32'd1);
      check({tag, "_res_valid"},   32'(bus.res_valid),   32'd0);
      check({tag, "_res_last"},    32'(bus.res_last),    32'd0);
      check({tag, "_res_data"},    32'(bus.res_data),    32'd0);
      check({tag, "_done"},        32'(bus.done),        32'd0);
      check({tag, "_match_count"}, 32'(bus.match_count), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int d0;
      int ready_high;
      bus.req_valid = 1'b0;
      bus.req_value = 4'd0;
      bus.abort     = 1'b0;
      reset         = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Target 4, always ready: exact latency and final count.
      rr_mode = 0;
      d0 = done_count;
      issue(4, 1'b0);
      wait_done(200, cyc);
      check("t4_done_cycle", 32'(cyc), 32'd69);
      check("t4_match_count", 32'(bus.match_count), 32'd4);
      check("t4_queue_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      check("t4_done_count", 32'(done_count - d0), 32'd1);
      check("t4_req_ready_after", 32'(bus.req_ready), 32'd1);
      check("t4_match_count_held", 32'(bus.match_count), 32'd4);

      // Target 12, consumer stalls five cycles on every result.
      rr_mode = 2;
      issue(12, 1'b0);
      wait_done(400, cyc);
      check("t12_done_after_last_hs", 32'($time - last_hs_time), 32'd6);
      check("t12_queue_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;

      // Target 0, abort while preimage 10 waits in HOLD (abort beats res_ready).
      rr_mode = 0;
      d0 = done_count;
      issue(0, 1'b0);
      cyc = 0;
      while (!(bus.res_valid && bus.res_data == 6'd10) && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 100) fail_now("abort_wait", "preimage 10 never presented");
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      check("abort_req_ready", 32'(bus.req_ready), 32'd1);
      check("abort_res_valid", 32'(bus.res_valid), 32'd0);
      check("abort_res_last", 32'(bus.res_last), 32'd0);
      check("abort_match_count", 32'(bus.match_count), 32'd1);
      check("abort_left_unsent", 32'(exp_q.size()), 32'd3);
      exp_q.delete();
      repeat (80) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_count - d0), 32'd0);
      check("abort_still_idle", 32'(bus.req_ready), 32'd1);

      // Reset mid-scan at cnt=30 (results 3 and 10 already consumed).
      issue(0, 1'b0);
      repeat (32) @(posedge clk);
      #1;
      check("midscan_match_count", 32'(bus.match_count), 32'd2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_values("midreset");
      check("midreset_left_unsent", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      rr_mode = 1;
      issue(0, 1'b0);
      wait_done(400, cyc);
      check("after_reset_queue_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;

      // req_valid held for the whole search: only one search, req_ready low until done.
      rr_mode = 0;
      d0 = done_count;
      ready_high = 0;
      cur_target = 7;
      last_res = -1;
      push_expected(7);
      bus.req_value = 4'd7;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      cyc = 1;
      while (!bus.done && cyc < 200) begin
         if (bus.req_ready) ready_high++;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!bus.done) fail_now("held_done_timeout", "no done while req_valid held");
      check("held_req_ready_during_search", 32'(ready_high + int'(bus.req_ready)), 32'd0);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("held_req_ready_after_done", 32'(bus.req_ready), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      check("held_one_search", 32'(done_count - d0), 32'd1);
      check("held_queue_drained", 32'(exp_q.size()), 32'd0);

      // Abort in IDLE is ignored, and a request with abort in the same cycle is accepted.
      bus.abort = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_abort_req_ready", 32'(bus.req_ready), 32'd1);
      check("idle_abort_match_count", 32'(bus.match_count), 32'd4);
      bus.abort = 1'b0;
      rr_mode = 1;
      issue(9, 1'b1);
      wait_done(400, cyc);
      check("req_with_abort_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;

      // Sweep all 16 targets with a random consumer.
      for (int t = 0; t < 16; t++) begin
         d0 = done_count;
         issue(t, 1'b0);
         wait_done(400, cyc);
         @(posedge clk);
         #1;
         check($sformatf("sweep%0d_drained", t), 32'(exp_q.size()), 32'd0);
         check($sformatf("sweep%0d_done", t), 32'(done_count - d0), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/s7_inverse_search.md
S7_INVERSE_SEARCH -- requirements
Module: s7_inverse_search

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  search request present.
REQ-005 req_value  input  4  target S7 output value [4:1].
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 abort  input  1  cancel the search in progress.
REQ-008 res_valid  output  1  res_data holds a preimage.
REQ-009 res_data  output  6  6-bit S7 input [6:1] that maps to the target.
REQ-010 res_last  output  1  res_data is the 4th preimage of this search.
REQ-011 res_ready  input  1  consumer accepts res_data.
REQ-012 done  output  1  one-cycle pulse at search end.
REQ-013 match_count  output  3  preimages accepted so far in this search (0..4).

Function
REQ-014 The block SHALL instantiate the codebase S7 lookup and evaluate it on a 6-bit candidate counter cnt.
REQ-015 FSM states: IDLE, SCAN, HOLD, DONE; all outputs registered.
REQ-016 IDLE: req_ready=1; on req_valid=1, capture req_value as target, clear cnt and match_count, and go to SCAN.
REQ-017 SCAN, one candidate per cycle: on S7(cnt)==target, load res_data=cnt, set res_valid=1, set res_last=1 if match_count==3, and go to HOLD with cnt held.
REQ-018 SCAN on a miss: if cnt==63 go to DONE, else increment cnt.
REQ-019 HOLD: res_valid, res_data and res_last SHALL stay stable until res_ready=1.
REQ-020 HOLD on res_ready=1: clear res_valid and res_last and increment match_count.
REQ-021 HOLD exit after that handshake: if cnt==63 go to DONE, else increment cnt and return to SCAN.
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE; match_count holds its value until the next request.
REQ-023 req_ready SHALL be 0 in SCAN, HOLD and DONE; req_valid in those states SHALL be ignored and not queued.
REQ-024 Preimages SHALL be emitted in strictly ascending res_data order.
REQ-025 Exactly 4 preimages exist for every target; match_count SHALL saturate at 4.
REQ-026 cnt wrap-around SHALL never occur: cnt==63 terminates the scan in both SCAN and HOLD.
REQ-027 With res_ready held at 1, done SHALL assert on the 69th cycle after the acceptance edge (64 SCAN cycles + 4 HOLD cycles).
REQ-028 abort=1 in SCAN, HOLD or DONE SHALL force IDLE on the next edge, clear res_valid, res_last and done, and leave match_count as is; abort has priority over res_ready.
REQ-029 abort in IDLE SHALL have no effect; a request and an abort in the same IDLE cycle SHALL accept the request.

Reset
REQ-030 Reset SHALL take priority over all inputs, in any state, including mid-search.
REQ-031 Reset SHALL force the IDLE state.
REQ-032 Reset values SHALL be: req_ready=1, res_valid=0, res_last=0, res_data=0, done=0, match_count=0, cnt=0, target=0.

Verification
REQ-033 req_value=4, res_ready=1 -> res_data 0, 9, 34, 43; res_last only with 43; done at cycle 69; match_count=4.
REQ-034 req_value=12, res_ready low 5 cycles at each match -> res_data 18, 23, 40, 63, each held stable while waiting; done one cycle after the 63 handshake.
REQ-035 req_value=0, abort asserted while res_data=10 is in HOLD -> IDLE next cycle, res_valid=0, match_count=1, no done pulse.
REQ-036 reset pulsed mid-SCAN (cnt=30) -> all outputs at reset values next cycle; a new request with req_value=0 then yields 3, 10, 53, 56.
REQ-037 req_valid held high for the whole search -> exactly one search runs; req_ready returns to 1 only after done.
REQ-038 All 16 targets swept with random res_ready -> each returns 4 distinct ascending preimages, and S7 of each equals the target.
